// File: rtl/axi4_burst_checker_if.sv
// Purpose: AXI4 master/slave bundle used by axi4_burst_checker.
// Ports (signals): AW, W, B, AR and R channel signals without ID, LOCK, CACHE,
//   PROT, QOS or USER fields. Those are tied off at the wrapper level.
//   master modport drives addresses/data/valids; slave modport drives readies,
//   responses and read data.
interface axi4_burst_checker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_burst_checker.sv
// Purpose: AXI4 burst self-test master. On a rising INIT_AXI_TXN edge it writes
//   NUM_BURSTS INCR bursts of a deterministic pattern from BASE_ADDR, reads the
//   region back, compares every beat and reports done / error.
// Ports:
//   ACLK         clock, rising edge
//   ARESET       asynchronous active-high reset
//   INIT_AXI_TXN start request (rising edge, honoured in IDLE/DONE only)
//   TXN_DONE     pass complete (level, held until next start or reset)
//   ERROR        sticky: data mismatch, RLAST mismatch or SLVERR/DECERR response
//   ERR_BEATS    mismatching read beats, saturating
//   m_axi        AXI4 master interface
// Build option: define AXI4_BURST_CHECKER_LFSR_EN to replace the incrementing
//   pattern with a 32-bit Galois LFSR replicated across the data bus.
//
// state   | meaning
// IDLE    | waiting for first start edge
// WR_ADDR | AWVALID held until AWREADY
// WR_DATA | streaming BURST_LEN write beats
// WR_RESP | waiting for BVALID
// RD_ADDR | ARVALID held until ARREADY
// RD_DATA | accepting and checking BURST_LEN read beats
// DONE    | pass finished, TXN_DONE high
module axi4_burst_checker #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    BURST_LEN  = 8,
  parameter int                    NUM_BURSTS = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h4000_0000,
  parameter logic [31:0]           SEED       = 32'd1
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 INIT_AXI_TXN,
  output logic                 TXN_DONE,
  output logic                 ERROR,
  output logic [15:0]          ERR_BEATS,
  axi4_burst_checker_if.master m_axi
);

  localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0]    LAST_BURST  = BURST_W'(NUM_BURSTS - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  logic [DATA_WIDTH-1:0] cur_data;

`ifdef AXI4_BURST_CHECKER_LFSR_EN
  localparam int               PAT_W     = 32;
  localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;
  localparam logic [PAT_W-1:0] PAT_INIT  = (SEED == 32'd0) ? 32'd1 : SEED;

  function automatic logic [PAT_W-1:0] pat_next(input logic [PAT_W-1:0] p);
    return p[0] ? ((p >> 1) ^ LFSR_TAPS) : (p >> 1);
  endfunction
`else
  localparam int               PAT_W    = DATA_WIDTH;
  localparam logic [PAT_W-1:0] PAT_INIT = PAT_W'(SEED);

  function automatic logic [PAT_W-1:0] pat_next(input logic [PAT_W-1:0] p);
    return p + PAT_W'(1);
  endfunction
`endif

  state_t                state_q;
  logic                  init_q;
  logic                  start;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BEAT_W-1:0]     beat_left_q;
  logic [BURST_W-1:0]    burst_left_q;
  logic [PAT_W-1:0]      pat_q;
  logic                  awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
  logic                  done_q, error_q;
  logic [15:0]           err_beats_q;
  logic                  unused_resp;

`ifdef AXI4_BURST_CHECKER_LFSR_EN
  assign cur_data = {(DATA_WIDTH / 32){pat_q}};
`else
  assign cur_data = pat_q;
`endif

  assign start = INIT_AXI_TXN & ~init_q;

  // Only the error bit of each response matters; OKAY vs EXOKAY is irrelevant.
  assign unused_resp = m_axi.bresp[0] ^ m_axi.rresp[0];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      init_q       <= 1'b0;
      addr_q       <= BASE_ADDR;
      beat_left_q  <= '0;
      burst_left_q <= '0;
      pat_q        <= PAT_INIT;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_beats_q  <= '0;
    end else begin
      init_q <= INIT_AXI_TXN;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_beats_q  <= '0;
            addr_q       <= BASE_ADDR;
            burst_left_q <= LAST_BURST;
            pat_q        <= PAT_INIT;
            awvalid_q    <= 1'b1;
            state_q      <= WR_ADDR;
          end
        end
        WR_ADDR: begin
          if (m_axi.awready) begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b1;
            wlast_q     <= (LAST_BEAT == '0);
            beat_left_q <= LAST_BEAT;
            state_q     <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (m_axi.wready) begin
            pat_q <= pat_next(pat_q);
            if (beat_left_q == '0) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= WR_RESP;
            end else begin
              beat_left_q <= beat_left_q - 1'b1;
              wlast_q     <= (beat_left_q == BEAT_W'(1));
            end
          end
        end
        WR_RESP: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            if (m_axi.bresp[1]) error_q <= 1'b1;
            if (burst_left_q == '0) begin
              // Rewind to the start of the region so the read pass regenerates
              // the same pattern sequence.
              addr_q       <= BASE_ADDR;
              pat_q        <= PAT_INIT;
              burst_left_q <= LAST_BURST;
              arvalid_q    <= 1'b1;
              state_q      <= RD_ADDR;
            end else begin
              addr_q       <= addr_q + BURST_BYTES;
              burst_left_q <= burst_left_q - 1'b1;
              awvalid_q    <= 1'b1;
              state_q      <= WR_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m_axi.arready) begin
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b1;
            beat_left_q <= LAST_BEAT;
            state_q     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi.rvalid) begin
            pat_q <= pat_next(pat_q);
            if (m_axi.rdata != cur_data) begin
              error_q <= 1'b1;
              if (err_beats_q != 16'hFFFF) err_beats_q <= err_beats_q + 16'd1;
            end
            if (m_axi.rresp[1]) error_q <= 1'b1;
            if (m_axi.rlast != (beat_left_q == '0)) error_q <= 1'b1;
            // The burst length is ours, not the slave's: stop on our count.
            if (beat_left_q == '0) begin
              rready_q <= 1'b0;
              if (burst_left_q == '0) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                addr_q       <= addr_q + BURST_BYTES;
                burst_left_q <= burst_left_q - 1'b1;
                arvalid_q    <= 1'b1;
                state_q      <= RD_ADDR;
              end
            end else begin
              beat_left_q <= beat_left_q - 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.awlen   = 8'(BURST_LEN - 1);
  assign m_axi.arlen   = 8'(BURST_LEN - 1);
  assign m_axi.awsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi.arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi.awburst = 2'b01;
  assign m_axi.arburst = 2'b01;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = cur_data;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign TXN_DONE  = done_q;
  assign ERROR     = error_q;
  assign ERR_BEATS = err_beats_q;

endmodule

// File: tb/tb_axi4_burst_checker.sv
module tb_axi4_burst_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance A: default parameters ----------------
  logic        rst_a  = 1'b1;
  logic        init_a = 1'b0;
  logic        done_a, err_a;
  logic [15:0] errb_a;

  axi4_burst_checker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifa ();

  axi4_burst_checker dut_a (
    .ACLK(clk), .ARESET(rst_a), .INIT_AXI_TXN(init_a),
    .TXN_DONE(done_a), .ERROR(err_a), .ERR_BEATS(errb_a), .m_axi(ifa)
  );

  bit stall_en        = 1'b0;
  bit drop_rlast      = 1'b0;
  int corrupt_idx     = -1;
  int bresp_err_burst = -1;

  logic [31:0] mem_a   [32];
  logic [31:0] a_awlog [8];
  logic [31:0] a_arlog [8];
  logic [31:0] a_wlog  [40];
  logic        a_llog  [40];
  int a_awcnt, a_arcnt, a_wcnt, a_rcnt, a_bcnt, a_wviol, a_wptr, a_rptr, a_rleft;
  logic        a_prev_stall;
  logic [31:0] a_prev_wdata;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      ifa.awready <= 1'b0; ifa.wready <= 1'b0; ifa.bvalid <= 1'b0; ifa.bresp <= 2'b00;
      ifa.arready <= 1'b0; ifa.rvalid <= 1'b0; ifa.rdata <= '0; ifa.rresp <= 2'b00;
      ifa.rlast   <= 1'b0;
      a_awcnt = 0; a_arcnt = 0; a_wcnt = 0; a_rcnt = 0; a_bcnt = 0; a_wviol = 0;
      a_wptr = 0; a_rptr = 0; a_rleft = 0; a_prev_stall = 1'b0; a_prev_wdata = '0;
    end else begin
      if (a_prev_stall && ifa.wvalid && ifa.wdata !== a_prev_wdata) a_wviol++;
      a_prev_stall = ifa.wvalid && !ifa.wready;
      a_prev_wdata = ifa.wdata;
      if (ifa.awvalid && ifa.awready) begin
        if (a_awcnt < 8) a_awlog[a_awcnt] = ifa.awaddr;
        a_awcnt++;
        a_wptr = int'((ifa.awaddr - 32'h4000_0000) >> 2);
      end
      if (ifa.bvalid && ifa.bready) ifa.bvalid <= 1'b0;
      if (ifa.wvalid && ifa.wready) begin
        mem_a[a_wptr % 32] = ifa.wdata;
        if (a_wcnt < 40) begin
          a_wlog[a_wcnt] = ifa.wdata;
          a_llog[a_wcnt] = ifa.wlast;
        end
        a_wcnt++;
        a_wptr++;
        if (ifa.wlast) begin
          ifa.bvalid <= 1'b1;
          ifa.bresp  <= (a_bcnt == bresp_err_burst) ? 2'b10 : 2'b00;
          a_bcnt++;
        end
      end
      if (ifa.arvalid && ifa.arready) begin
        if (a_arcnt < 8) a_arlog[a_arcnt] = ifa.araddr;
        a_arcnt++;
        a_rptr  = int'((ifa.araddr - 32'h4000_0000) >> 2);
        a_rleft = 8;
      end
      if (ifa.rvalid && ifa.rready) begin
        a_rcnt++;
        a_rptr++;
        a_rleft--;
      end
      if (!(ifa.rvalid && !ifa.rready)) begin
        if (a_rleft > 0 && (!stall_en || $urandom_range(0, 1) == 1)) begin
          ifa.rvalid <= 1'b1;
          ifa.rdata  <= (a_rcnt == corrupt_idx) ? 32'h0000_DEAD : mem_a[a_rptr % 32];
          ifa.rlast  <= (a_rleft == 1) && !drop_rlast;
        end else begin
          ifa.rvalid <= 1'b0;
        end
      end
      ifa.awready <= !stall_en || ($urandom_range(0, 1) == 1);
      ifa.wready  <= !stall_en || ($urandom_range(0, 1) == 1);
      ifa.arready <= !stall_en || ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- instance W: 64-bit, 256-beat bursts ----------------
  logic        rst_w  = 1'b1;
  logic        init_w = 1'b0;
  logic        done_w, err_w;
  logic [15:0] errb_w;

  axi4_burst_checker_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) ifw ();

  axi4_burst_checker #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .BURST_LEN(256), .NUM_BURSTS(2),
    .BASE_ADDR(32'h4000_0000), .SEED(32'hFFFF_FFF0)
  ) dut_w (
    .ACLK(clk), .ARESET(rst_w), .INIT_AXI_TXN(init_w),
    .TXN_DONE(done_w), .ERROR(err_w), .ERR_BEATS(errb_w), .m_axi(ifw)
  );

  logic [63:0] mem_w   [512];
  logic [63:0] w_wlog  [512];
  logic        w_llog  [512];
  logic [31:0] w_awlog [4];
  int w_awcnt, w_wcnt, w_rcnt, w_wptr, w_rptr, w_rleft;

  always @(posedge clk or posedge rst_w) begin
    if (rst_w) begin
      ifw.awready <= 1'b0; ifw.wready <= 1'b0; ifw.bvalid <= 1'b0; ifw.bresp <= 2'b00;
      ifw.arready <= 1'b0; ifw.rvalid <= 1'b0; ifw.rdata <= '0; ifw.rresp <= 2'b00;
      ifw.rlast   <= 1'b0;
      w_awcnt = 0; w_wcnt = 0; w_rcnt = 0; w_wptr = 0; w_rptr = 0; w_rleft = 0;
    end else begin
      if (ifw.awvalid && ifw.awready) begin
        if (w_awcnt < 4) w_awlog[w_awcnt] = ifw.awaddr;
        w_awcnt++;
        w_wptr = int'((ifw.awaddr - 32'h4000_0000) >> 3);
      end
      if (ifw.bvalid && ifw.bready) ifw.bvalid <= 1'b0;
      if (ifw.wvalid && ifw.wready) begin
        mem_w[w_wptr % 512] = ifw.wdata;
        if (w_wcnt < 512) begin
          w_wlog[w_wcnt] = ifw.wdata;
          w_llog[w_wcnt] = ifw.wlast;
        end
        w_wcnt++;
        w_wptr++;
        if (ifw.wlast) ifw.bvalid <= 1'b1;
      end
      if (ifw.arvalid && ifw.arready) begin
        w_rptr  = int'((ifw.araddr - 32'h4000_0000) >> 3);
        w_rleft = 256;
      end
      if (ifw.rvalid && ifw.rready) begin
        w_rcnt++;
        w_rptr++;
        w_rleft--;
      end
      if (!(ifw.rvalid && !ifw.rready)) begin
        if (w_rleft > 0) begin
          ifw.rvalid <= 1'b1;
          ifw.rdata  <= mem_w[w_rptr % 512];
          ifw.rlast  <= (w_rleft == 1);
        end else begin
          ifw.rvalid <= 1'b0;
        end
      end
      ifw.awready <= 1'b1;
      ifw.wready  <= 1'b1;
      ifw.arready <= 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset_a();
    @(negedge clk) rst_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic pulse_a();
    @(negedge clk) init_a = 1'b1;
    @(negedge clk) init_a = 1'b0;
  endtask

  task automatic wait_done_a(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done_a === 1'b1) break;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    total++; if (ifa.awvalid !== 1'b0) begin bad++; $display("FAIL rst_awvalid: got %b want 0", ifa.awvalid); end
    total++; if (ifa.wvalid !== 1'b0) begin bad++; $display("FAIL rst_wvalid: got %b want 0", ifa.wvalid); end
    total++; if (ifa.wlast !== 1'b0) begin bad++; $display("FAIL rst_wlast: got %b want 0", ifa.wlast); end
    total++; if (ifa.bready !== 1'b0) begin bad++; $display("FAIL rst_bready: got %b want 0", ifa.bready); end
    total++; if (ifa.arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid: got %b want 0", ifa.arvalid); end
    total++; if (ifa.rready !== 1'b0) begin bad++; $display("FAIL rst_rready: got %b want 0", ifa.rready); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done_a); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", err_a); end
    total++; if (errb_a !== 16'd0) begin bad++; $display("FAIL rst_err_beats: got %0d want 0", errb_a); end
    total++; if (ifa.awaddr !== 32'h4000_0000) begin bad++; $display("FAIL rst_awaddr: got %h want 40000000", ifa.awaddr); end
    total++; if (ifa.araddr !== 32'h4000_0000) begin bad++; $display("FAIL rst_araddr: got %h want 40000000", ifa.araddr); end
    rst_a = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (ifa.awvalid !== 1'b0) begin bad++; $display("FAIL idle_no_start: awvalid got %b want 0", ifa.awvalid); end
  endtask

  task automatic test_basic();
    int dbad;
    apply_reset_a();
    stall_en = 1'b0;
    wait (($time % 10) == 0 && $time >= 200);
    pulse_a();
    wait_done_a(2000);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", done_a); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL basic_error: got %b want 0", err_a); end
    total++; if (errb_a !== 16'd0) begin bad++; $display("FAIL basic_err_beats: got %0d want 0", errb_a); end
    total++; if (a_awcnt !== 4) begin bad++; $display("FAIL basic_aw_count: got %0d want 4", a_awcnt); end
    total++; if (a_arcnt !== 4) begin bad++; $display("FAIL basic_ar_count: got %0d want 4", a_arcnt); end
    total++; if (a_wcnt !== 32) begin bad++; $display("FAIL basic_w_count: got %0d want 32", a_wcnt); end
    total++; if (a_rcnt !== 32) begin bad++; $display("FAIL basic_r_count: got %0d want 32", a_rcnt); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (a_awlog[i] !== 32'h4000_0000 + 32'(i * 32)) begin
        bad++; $display("FAIL basic_awaddr%0d: got %h want %h", i, a_awlog[i], 32'h4000_0000 + 32'(i * 32));
      end
    end
    total++; if (a_arlog[3] !== 32'h4000_0060) begin bad++; $display("FAIL basic_araddr3: got %h want 40000060", a_arlog[3]); end
    dbad = 0;
    for (int i = 0; i < 32; i++)
      if (a_wlog[i] !== 32'(i + 1) || a_llog[i] !== ((i % 8) == 7)) dbad++;
    total++; if (dbad !== 0) begin bad++; $display("FAIL basic_wdata_wlast: got %0d bad beats want 0", dbad); end
    total++; if (ifa.awlen !== 8'd7) begin bad++; $display("FAIL awlen: got %0d want 7", ifa.awlen); end
    total++; if (ifa.arsize !== 3'd2) begin bad++; $display("FAIL arsize: got %0d want 2", ifa.arsize); end
    total++; if (ifa.awburst !== 2'b01) begin bad++; $display("FAIL awburst: got %b want 01", ifa.awburst); end
    total++; if (ifa.wstrb !== 4'hF) begin bad++; $display("FAIL wstrb: got %h want f", ifa.wstrb); end
    repeat (3) @(negedge clk);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL basic_done_hold: got %b want 1", done_a); end
  endtask

  task automatic test_corrupt();
    apply_reset_a();
    corrupt_idx = 10;
    pulse_a();
    wait_done_a(2000);
    corrupt_idx = -1;
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL corrupt_done: got %b want 1", done_a); end
    total++; if (err_a !== 1'b1) begin bad++; $display("FAIL corrupt_error: got %b want 1", err_a); end
    total++; if (errb_a !== 16'd1) begin bad++; $display("FAIL corrupt_err_beats: got %0d want 1", errb_a); end
    total++; if (a_rcnt !== 32) begin bad++; $display("FAIL corrupt_r_count: got %0d want 32", a_rcnt); end
  endtask

  task automatic test_back_to_back();
    // Restart straight from DONE with the error flags still set.
    pulse_a();
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL b2b_done_clear: got %b want 0", done_a); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL b2b_error_clear: got %b want 0", err_a); end
    total++; if (errb_a !== 16'd0) begin bad++; $display("FAIL b2b_err_beats_clear: got %0d want 0", errb_a); end
    total++; if (ifa.awvalid !== 1'b1) begin bad++; $display("FAIL b2b_awvalid: got %b want 1", ifa.awvalid); end
    wait_done_a(2000);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", done_a); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL b2b_error: got %b want 0", err_a); end
  endtask

  task automatic test_stalls();
    int dbad;
    apply_reset_a();
    stall_en = 1'b1;
    pulse_a();
    wait_done_a(4000);
    stall_en = 1'b0;
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL stall_done: got %b want 1", done_a); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL stall_error: got %b want 0", err_a); end
    total++; if (a_wviol !== 0) begin bad++; $display("FAIL stall_wdata_stable: got %0d changes want 0", a_wviol); end
    total++; if (a_wcnt !== 32) begin bad++; $display("FAIL stall_w_count: got %0d want 32", a_wcnt); end
    dbad = 0;
    for (int i = 0; i < 32; i++)
      if (a_wlog[i] !== 32'(i + 1) || a_llog[i] !== ((i % 8) == 7)) dbad++;
    total++; if (dbad !== 0) begin bad++; $display("FAIL stall_wdata: got %0d bad beats want 0", dbad); end
  endtask

  task automatic test_bresp_err();
    apply_reset_a();
    bresp_err_burst = 1;
    pulse_a();
    wait_done_a(2000);
    bresp_err_burst = -1;
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL bresp_done: got %b want 1", done_a); end
    total++; if (err_a !== 1'b1) begin bad++; $display("FAIL bresp_error: got %b want 1", err_a); end
    total++; if (errb_a !== 16'd0) begin bad++; $display("FAIL bresp_err_beats: got %0d want 0", errb_a); end
    total++; if (a_rcnt !== 32) begin bad++; $display("FAIL bresp_r_count: got %0d want 32", a_rcnt); end
  endtask

  task automatic test_rlast_missing();
    apply_reset_a();
    drop_rlast = 1'b1;
    pulse_a();
    wait_done_a(2000);
    drop_rlast = 1'b0;
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL rlast_done: got %b want 1", done_a); end
    total++; if (err_a !== 1'b1) begin bad++; $display("FAIL rlast_error: got %b want 1", err_a); end
    total++; if (errb_a !== 16'd0) begin bad++; $display("FAIL rlast_err_beats: got %0d want 0", errb_a); end
  endtask

  task automatic test_reset_mid();
    apply_reset_a();
    pulse_a();
    for (int i = 0; i < 200 && a_wcnt < 3; i++) @(negedge clk);
    total++; if (a_wcnt !== 3) begin bad++; $display("FAIL mid_reach_beat3: got %0d want 3", a_wcnt); end
    total++; if (ifa.wvalid !== 1'b1) begin bad++; $display("FAIL mid_wvalid_pre: got %b want 1", ifa.wvalid); end
    #2 rst_a = 1'b1;
    #1;
    total++; if (ifa.wvalid !== 1'b0) begin bad++; $display("FAIL mid_wvalid_reset: got %b want 0", ifa.wvalid); end
    total++; if (ifa.awvalid !== 1'b0) begin bad++; $display("FAIL mid_awvalid_reset: got %b want 0", ifa.awvalid); end
    total++; if (ifa.awaddr !== 32'h4000_0000) begin bad++; $display("FAIL mid_awaddr_reset: got %h want 40000000", ifa.awaddr); end
    @(negedge clk) rst_a = 1'b0;
    pulse_a();
    wait_done_a(2000);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL mid_done: got %b want 1", done_a); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL mid_error: got %b want 0", err_a); end
    total++; if (a_wcnt !== 32) begin bad++; $display("FAIL mid_w_count: got %0d want 32", a_wcnt); end
  endtask

  task automatic test_wide();
    int dbad;
    @(negedge clk) rst_w = 1'b0;
    @(negedge clk) init_w = 1'b1;
    @(negedge clk) init_w = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done_w === 1'b1) break;
      @(negedge clk);
    end
    total++; if (done_w !== 1'b1) begin bad++; $display("FAIL wide_done: got %b want 1", done_w); end
    total++; if (err_w !== 1'b0) begin bad++; $display("FAIL wide_error: got %b want 0", err_w); end
    total++; if (errb_w !== 16'd0) begin bad++; $display("FAIL wide_err_beats: got %0d want 0", errb_w); end
    total++; if (w_awcnt !== 2) begin bad++; $display("FAIL wide_aw_count: got %0d want 2", w_awcnt); end
    total++; if (w_awlog[1] !== 32'h4000_0800) begin bad++; $display("FAIL wide_awaddr1: got %h want 40000800", w_awlog[1]); end
    total++; if (w_wcnt !== 512) begin bad++; $display("FAIL wide_w_count: got %0d want 512", w_wcnt); end
    total++; if (w_rcnt !== 512) begin bad++; $display("FAIL wide_r_count: got %0d want 512", w_rcnt); end
    total++; if (w_wlog[16] !== 64'h0000_0001_0000_0000) begin bad++; $display("FAIL wide_carry: got %h want 0000000100000000", w_wlog[16]); end
    dbad = 0;
    for (int i = 0; i < 512; i++)
      if (w_wlog[i] !== 64'h0000_0000_FFFF_FFF0 + 64'(i) || w_llog[i] !== ((i % 256) == 255)) dbad++;
    total++; if (dbad !== 0) begin bad++; $display("FAIL wide_wdata_wlast: got %0d bad beats want 0", dbad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corrupt();
    test_back_to_back();
    test_stalls();
    test_bresp_err();
    test_rlast_missing();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
